// File: rtl/seg_disp_pkg.sv
// Shared encodings for the seven-segment display arbiter: field select and loader choose codes.
package seg_disp_pkg;

   typedef enum logic [1:0] {
      CHOOSE_IDLE  = 2'b00,
      CHOOSE_LEFT  = 2'b01,
      CHOOSE_RIGHT = 2'b10
   } choose_e;

   localparam logic FIELD_LEFT  = 1'b0;
   localparam logic FIELD_RIGHT = 1'b1;

   function automatic logic [1:0] choose_for(input logic field);
      return (field == FIELD_RIGHT) ? CHOOSE_RIGHT : CHOOSE_LEFT;
   endfunction

endpackage

// File: rtl/seg_disp_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping mod N.
// Zero latency; the owner of ptr decides when it advances.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  elig,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!valid && elig[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin sharing of the two 3-digit display fields; one write per cycle, outputs one cycle after grant.
// A written field stays locked for HOLD_CYC cycles; requesters simply wait (req held) until granted.
module seg_disp_arbiter
   import seg_disp_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int HOLD_W   = 24,
   parameter int HOLD_CYC = 12_500_000
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     req_field,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     ack,
   output logic [7:0]           bin,
   output logic [1:0]           choose,
   output logic [1:0]           field_lock
);

   localparam int PW = $clog2(N_REQ);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);

   logic [1:0][HOLD_W-1:0] hold_cnt;
   logic [PW-1:0]          ptr;
   logic [PW-1:0]          ptr_nxt;
   logic [N_REQ-1:0]       elig;
   logic [N_REQ-1:0]       grant;
   logic                   valid;
   logic [PW-1:0]          gidx;
   logic                   g_field;
   logic [7:0]             g_data;

   assign field_lock = {hold_cnt[1] != '0, hold_cnt[0] != '0};

   // A requester acked this cycle is still holding req; keep it out so it cannot win twice.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++)
         elig[i] = req[i] & ~field_lock[req_field[i]] & ~ack[i];
   end

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
      .elig  (elig),
      .ptr   (ptr),
      .grant (grant),
      .valid (valid)
   );

   always_comb begin
      gidx    = '0;
      g_field = FIELD_LEFT;
      g_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            gidx    = PW'(i);
            g_field = req_field[i];
            g_data  = req_data[8*i +: 8];
         end
      end
      ptr_nxt = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ack      <= '0;
         bin      <= '0;
         choose   <= CHOOSE_IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         ack <= grant;
         if (valid) begin
            bin    <= g_data;
            choose <= choose_for(g_field);
            ptr    <= ptr_nxt;
         end else begin
            choose <= CHOOSE_IDLE;
         end
         // Load on grant, otherwise count down and park at zero.
         for (int f = 0; f < 2; f++) begin
            if (valid && g_field == 1'(f))
               hold_cnt[f] <= HOLD_LOAD;
            else if (hold_cnt[f] != '0)
               hold_cnt[f] <= hold_cnt[f] - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Two arbiters (hold 4 and hold 0) checked every cycle against a timestamp-based model,
// with directed scenarios followed by randomized request traffic.
module tb_seg_disp_arbiter;

   localparam int N = 4;
   localparam int HOLD [2] = '{4, 0};

   logic clk = 1'b0;
   logic rstn;
   logic [N-1:0]   req  [2];
   logic [N-1:0]   fld  [2];
   logic [8*N-1:0] dat  [2];
   logic [N-1:0]   ack_o    [2];
   logic [7:0]     bin_o    [2];
   logic [1:0]     choose_o [2];
   logic [1:0]     lock_o   [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model: pointer, last locked cycle per field, and the outputs expected in the current cycle.
   int         m_ptr    [2];
   int         lock_end [2][2];
   logic [N-1:0] e_ack  [2];
   logic [7:0]   e_bin  [2];
   logic [1:0]   e_choose [2];

   always #5 clk = ~clk;

   seg_disp_arbiter #(.N_REQ(N), .HOLD_W(24), .HOLD_CYC(4)) u_dut0 (
      .clk(clk), .rstn(rstn), .req(req[0]), .req_field(fld[0]), .req_data(dat[0]),
      .ack(ack_o[0]), .bin(bin_o[0]), .choose(choose_o[0]), .field_lock(lock_o[0])
   );

   seg_disp_arbiter #(.N_REQ(N), .HOLD_W(24), .HOLD_CYC(0)) u_dut1 (
      .clk(clk), .rstn(rstn), .req(req[1]), .req_field(fld[1]), .req_data(dat[1]),
      .ack(ack_o[1]), .bin(bin_o[1]), .choose(choose_o[1]), .field_lock(lock_o[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic reset_model(input int d);
      m_ptr[d] = 0;
      lock_end[d][0] = -1;
      lock_end[d][1] = -1;
      e_ack[d] = '0;
      e_bin[d] = '0;
      e_choose[d] = 2'b00;
   endtask

   function automatic bit locked(input int d, input int f, input int t);
      return t <= lock_end[d][f];
   endfunction

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int g;
         g = -1;
         if (!rstn) begin
            reset_model(d);
         end else begin
            for (int k = 0; k < N; k++) begin
               int i;
               i = (m_ptr[d] + k) % N;
               if (g < 0 && req[d][i] && !locked(d, int'(fld[d][i]), cyc) && !e_ack[d][i])
                  g = i;
            end
            if (g >= 0) begin
               e_ack[d] = N'(1) << g;
               e_bin[d] = dat[d][8*g +: 8];
               e_choose[d] = fld[d][g] ? 2'b10 : 2'b01;
               m_ptr[d] = (g + 1) % N;
               lock_end[d][fld[d][g]] = cyc + HOLD[d];
            end else begin
               e_ack[d] = '0;
               e_choose[d] = 2'b00;
            end
         end
      end
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_ack", d), 32'(ack_o[d]), 32'(e_ack[d]));
         chk($sformatf("d%0d_choose", d), 32'(choose_o[d]), 32'(e_choose[d]));
         chk($sformatf("d%0d_lock", d), 32'(lock_o[d]),
             {30'd0, locked(d, 1, cyc), locked(d, 0, cyc)});
         if (e_choose[d] != 2'b00)
            chk($sformatf("d%0d_bin", d), 32'(bin_o[d]), 32'(e_bin[d]));
      end
   endtask

   // Inputs for the current cycle are already applied; clock them in and check the result.
   task automatic advance();
      model_step();
      @(negedge clk);
      cyc++;
      check_outputs();
   endtask

   task automatic wait_ack(input int d, input int b, output int at);
      at = -1;
      for (int n = 0; n < 12 && at < 0; n++) begin
         advance();
         if (ack_o[d][b]) at = cyc;
      end
   endtask

   task automatic set_req(input int d, input int i, input logic f, input logic [7:0] v);
      req[d][i] = 1'b1;
      fld[d][i] = f;
      dat[d][8*i +: 8] = v;
   endtask

   task automatic drive_random();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            if (req[d][i]) begin
               if (e_ack[d][i]) begin
                  if ($urandom_range(3) != 0) req[d][i] = 1'b0;
               end else if ($urandom_range(15) == 0) begin
                  req[d][i] = 1'b0;
               end
            end else if ($urandom_range(3) == 0) begin
               set_req(d, i, 1'($urandom_range(1)), 8'($urandom));
            end
         end
      end
   endtask

   initial begin
      int t0, at, prev, seen;
      rstn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req[d] = '0; fld[d] = '0; dat[d] = '0;
         reset_model(d);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ack", 32'(ack_o[d]), 32'd0);
         chk("rst_bin", 32'(bin_o[d]), 32'd0);
         chk("rst_choose", 32'(choose_o[d]), 32'd0);
         chk("rst_lock", 32'(lock_o[d]), 32'd0);
      end
      advance();
      rstn = 1'b1;

      // Round-robin over the right field: acks 0,1,2,3 five cycles apart.
      for (int i = 0; i < N; i++) set_req(0, i, 1'b1, 8'($urandom));
      t0 = cyc;
      prev = t0 - 4;
      for (int k = 0; k < N; k++) begin
         wait_ack(0, k, at);
         chk($sformatf("rr_gap%0d", k), 32'(at - prev), 32'd5);
         prev = at;
         req[0][k] = 1'b0;
      end

      // Single left write and its lock window.
      set_req(0, 2, 1'b0, 8'd123);
      advance();
      req[0][2] = 1'b0;
      chk("single_ack", 32'(ack_o[0]), 32'b0100);
      chk("single_bin", 32'(bin_o[0]), 32'd123);
      chk("single_choose", 32'(choose_o[0]), 32'b01);
      for (int k = 2; k <= 4; k++) begin
         advance();
         chk($sformatf("single_lock_t%0d", k), 32'(lock_o[0][0]), 32'd1);
      end
      advance();
      chk("single_unlock_t5", 32'(lock_o[0][0]), 32'd0);

      // Both fields written on consecutive cycles.
      set_req(0, 0, 1'b0, 8'd10);
      set_req(0, 1, 1'b1, 8'd200);
      advance();
      req[0][0] = 1'b0;
      chk("indep_ack0", 32'(ack_o[0]), 32'b0001);
      chk("indep_bin0", 32'(bin_o[0]), 32'd10);
      chk("indep_choose0", 32'(choose_o[0]), 32'b01);
      advance();
      req[0][1] = 1'b0;
      chk("indep_ack1", 32'(ack_o[0]), 32'b0010);
      chk("indep_bin1", 32'(bin_o[0]), 32'd200);
      chk("indep_choose1", 32'(choose_o[0]), 32'b10);

      // A left request arriving while left is locked waits for the lock to expire.
      repeat (4) advance();
      t0 = cyc;
      set_req(0, 0, 1'b0, 8'd77);
      advance();
      req[0][0] = 1'b0;
      advance();
      set_req(0, 3, 1'b0, 8'd255);
      wait_ack(0, 3, at);
      req[0][3] = 1'b0;
      chk("locked_wait_cycles", 32'(at - t0), 32'd6);
      chk("locked_wait_bin", 32'(bin_o[0]), 32'd255);
      chk("locked_wait_choose", 32'(choose_o[0]), 32'b01);

      // Asynchronous reset while a lock is active.
      advance();
      rstn = 1'b0;
      #1;
      chk("midrst_ack", 32'(ack_o[0]), 32'd0);
      chk("midrst_choose", 32'(choose_o[0]), 32'd0);
      chk("midrst_bin", 32'(bin_o[0]), 32'd0);
      chk("midrst_lock", 32'(lock_o[0]), 32'd0);
      advance();
      advance();
      rstn = 1'b1;
      set_req(0, 1, 1'b1, 8'd42);
      advance();
      req[0][1] = 1'b0;
      chk("postrst_ack", 32'(ack_o[0]), 32'b0010);
      chk("postrst_bin", 32'(bin_o[0]), 32'd42);

      // Zero hold: withdrawn request never acked; same-field writes back to back.
      set_req(1, 0, 1'b0, 8'h5a);
      set_req(1, 1, 1'b0, 8'ha5);
      advance();
      chk("h0_first_ack", 32'(ack_o[1]), 32'b0001);
      req[1] = '0;
      seen = 0;
      repeat (3) begin
         advance();
         if (ack_o[1][1]) seen++;
      end
      chk("h0_withdrawn", 32'(seen), 32'd0);
      set_req(1, 2, 1'b0, 8'd33);
      set_req(1, 3, 1'b0, 8'd44);
      advance();
      req[1][2] = 1'b0;
      chk("h0_b2b_ack2", 32'(ack_o[1]), 32'b0100);
      advance();
      req[1][3] = 1'b0;
      chk("h0_b2b_ack3", 32'(ack_o[1]), 32'b1000);
      chk("h0_b2b_bin3", 32'(bin_o[1]), 32'd44);
      chk("h0_b2b_lock", 32'(lock_o[1]), 32'd0);

      // Randomized traffic on both instances.
      for (int n = 0; n < 1500; n++) begin
         drive_random();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
